// File: rtl/nxn_game_ctrl.sv
// nxn_game_ctrl -- N x N two-player (X/O) line game controller.
//
// Holds the board, enforces turn order, rejects illegal moves, detects
// wins/draws one cycle after each accepted move, optionally forfeits an idle
// turn after TIMEOUT_CYC cycles, and restarts on new_game.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   new_game            synchronous restart, beats any move on the same edge
//   playX / playO       level move requests of each player
//   playerX_position    X target cell (row*N+col)
//   playerO_position    O target cell
//   board               packed cells, cell i at [2i+1:2i]: 00 empty, 01 X, 10 O
//   who                 00 in play, 01 X won, 10 O won, 11 draw
//   winner_play         bit i set when cell i lies on a winning line
//   turn                0 = X to move, 1 = O to move
//   illegal             1-cycle pulse: move of the player on turn rejected
//   timeout_evt         1-cycle pulse: turn forfeited by inactivity
//   done                game over (who != 00)
//   dbg_state           FSM state (00 TURN, 01 CHECK, 10 DONE)
//
// Request protocol: playX/playO act as "valid" with the position as payload.
// Only the player on turn is looked at, and only in TURN; the implicit "ready"
// is "state is TURN". A request that is accepted writes its cell on that edge;
// a request still held when TURN is re-entered is evaluated again.
module nxn_game_ctrl #(
  parameter int N           = 3,
  parameter int TIMEOUT_CYC = 0,
  parameter int FIRST_O     = 0,
  localparam int PW         = $clog2(N*N),
  localparam int TW         = $clog2(TIMEOUT_CYC+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              new_game,
  input  logic              playX,
  input  logic              playO,
  input  logic [PW-1:0]     playerX_position,
  input  logic [PW-1:0]     playerO_position,
  output logic [2*N*N-1:0]  board,
  output logic [1:0]        who,
  output logic [N*N-1:0]    winner_play,
  output logic              turn,
  output logic              illegal,
  output logic              timeout_evt,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int            NC    = N*N;
  localparam int            OW    = $clog2(NC+1);
  // Timer keeps at least one bit so a disabled timeout still elaborates.
  localparam int            TWI   = (TW < 1) ? 1 : TW;
  localparam logic [PW:0]   NC_P  = (PW+1)'(NC);
  localparam logic [OW-1:0] NC_O  = OW'(NC);
  localparam logic [TWI-1:0] TLAST = TWI'(TIMEOUT_CYC-1);
  localparam logic          FIRST = (FIRST_O != 0);

  typedef enum logic [1:0] {S_TURN = 2'b00, S_CHECK = 2'b01, S_DONE = 2'b10} state_t;

  state_t          state_q, state_d;
  logic [2*NC-1:0] board_q, board_d;
  logic [1:0]      who_q, who_d;
  logic [NC-1:0]   win_q, win_d;
  logic            turn_q, turn_d;
  logic            illegal_q, illegal_d;
  logic            tout_q, tout_d;
  logic [TWI-1:0]  timer_q, timer_d;
  logic [OW-1:0]   occ_q, occ_d;

  // Mover code: in CHECK, turn_q still names the player who just moved.
  logic [1:0]      mover;
  logic            req;
  logic [PW-1:0]   pos;
  logic            pos_ok;
  logic            cell_empty;
  logic [2*NC-1:0] place;
  logic            accept;
  logic            line_any;
  logic [NC-1:0]   line_mask;
  logic            hit;

  assign mover  = turn_q ? 2'b10 : 2'b01;
  assign req    = turn_q ? playO : playX;
  assign pos    = turn_q ? playerO_position : playerX_position;
  assign pos_ok = ({1'b0, pos} < NC_P);
  assign accept = req && pos_ok && cell_empty;

  // Target-cell decode done by comparison so an out-of-range position
  // never produces an out-of-range select.
  always_comb begin
    cell_empty = 1'b0;
    place      = '0;
    for (int i = 0; i < NC; i++) begin
      if (pos == PW'(i)) begin
        cell_empty        = (board_q[2*i +: 2] == 2'b00);
        place[2*i +: 2]   = mover;
      end
    end
  end

  // Line detection for the mover over rows, columns and both diagonals.
  always_comb begin
    line_any  = 1'b0;
    line_mask = '0;
    hit       = 1'b0;
    for (int r = 0; r < N; r++) begin
      hit = 1'b1;
      for (int c = 0; c < N; c++)
        if (board_q[2*(r*N+c) +: 2] != mover) hit = 1'b0;
      if (hit) begin
        line_any = 1'b1;
        for (int c = 0; c < N; c++) line_mask[r*N+c] = 1'b1;
      end
    end
    for (int c = 0; c < N; c++) begin
      hit = 1'b1;
      for (int r = 0; r < N; r++)
        if (board_q[2*(r*N+c) +: 2] != mover) hit = 1'b0;
      if (hit) begin
        line_any = 1'b1;
        for (int r = 0; r < N; r++) line_mask[r*N+c] = 1'b1;
      end
    end
    hit = 1'b1;
    for (int k = 0; k < N; k++)
      if (board_q[2*(k*N+k) +: 2] != mover) hit = 1'b0;
    if (hit) begin
      line_any = 1'b1;
      for (int k = 0; k < N; k++) line_mask[k*N+k] = 1'b1;
    end
    hit = 1'b1;
    for (int k = 0; k < N; k++)
      if (board_q[2*(k*N+N-1-k) +: 2] != mover) hit = 1'b0;
    if (hit) begin
      line_any = 1'b1;
      for (int k = 0; k < N; k++) line_mask[k*N+N-1-k] = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    who_d     = who_q;
    win_d     = win_q;
    turn_d    = turn_q;
    timer_d   = timer_q;
    occ_d     = occ_q;
    illegal_d = 1'b0;
    tout_d    = 1'b0;
    if (new_game) begin
      state_d = S_TURN;
      board_d = '0;
      who_d   = 2'b00;
      win_d   = '0;
      turn_d  = FIRST;
      timer_d = '0;
      occ_d   = '0;
    end else begin
      case (state_q)
        S_TURN: begin
          if (accept) begin
            board_d = board_q | place;
            occ_d   = occ_q + OW'(1);
            timer_d = '0;
            state_d = S_CHECK;
          end else begin
            illegal_d = req;
            // A move accepted on the expiry edge wins, hence the else branch.
            if (TIMEOUT_CYC > 0) begin
              if (timer_q == TLAST) begin
                tout_d  = 1'b1;
                turn_d  = ~turn_q;
                timer_d = '0;
              end else begin
                timer_d = timer_q + TWI'(1);
              end
            end
          end
        end
        S_CHECK: begin
          if (line_any) begin
            who_d   = mover;
            win_d   = line_mask;
            state_d = S_DONE;
          end else if (occ_q == NC_O) begin
            who_d   = 2'b11;
            win_d   = '0;
            state_d = S_DONE;
          end else begin
            turn_d  = ~turn_q;
            state_d = S_TURN;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_TURN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_TURN;
      board_q   <= '0;
      who_q     <= 2'b00;
      win_q     <= '0;
      turn_q    <= FIRST;
      illegal_q <= 1'b0;
      tout_q    <= 1'b0;
      timer_q   <= '0;
      occ_q     <= '0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      who_q     <= who_d;
      win_q     <= win_d;
      turn_q    <= turn_d;
      illegal_q <= illegal_d;
      tout_q    <= tout_d;
      timer_q   <= timer_d;
      occ_q     <= occ_d;
    end
  end

  assign board       = board_q;
  assign who         = who_q;
  assign winner_play = win_q;
  assign turn        = turn_q;
  assign illegal     = illegal_q;
  assign timeout_evt = tout_q;
  assign done        = (who_q != 2'b00);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_nxn_game_ctrl.sv
// Bench for nxn_game_ctrl: a 3x3 instance with an 8-cycle timeout checked
// every cycle against a game-rule model, plus a 4x4 instance for a diagonal win.
module tb_nxn_game_ctrl;

  localparam int NA   = 3;
  localparam int TO_A = 8;

  logic clk, rst;

  // Instance A: N=3, TIMEOUT_CYC=8, X first
  logic        ng_a, px_a, po_a;
  logic [3:0]  xp_a, op_a;
  logic [17:0] board_a;
  logic [1:0]  who_a, st_a;
  logic [8:0]  wp_a;
  logic        turn_a, ill_a, to_a, done_a;

  // Instance B: N=4, no timeout, X first
  logic        ng_b, px_b, po_b;
  logic [3:0]  xp_b, op_b;
  logic [31:0] board_b;
  logic [1:0]  who_b, st_b;
  logic [15:0] wp_b;
  logic        turn_b, ill_b, to_b, done_b;

  int n_chk = 0;
  int n_err = 0;

  nxn_game_ctrl #(.N(3), .TIMEOUT_CYC(TO_A), .FIRST_O(0)) u_a (
    .clk(clk), .rst(rst), .new_game(ng_a), .playX(px_a), .playO(po_a),
    .playerX_position(xp_a), .playerO_position(op_a), .board(board_a),
    .who(who_a), .winner_play(wp_a), .turn(turn_a), .illegal(ill_a),
    .timeout_evt(to_a), .done(done_a), .dbg_state(st_a)
  );

  nxn_game_ctrl #(.N(4), .TIMEOUT_CYC(0), .FIRST_O(0)) u_b (
    .clk(clk), .rst(rst), .new_game(ng_b), .playX(px_b), .playO(po_b),
    .playerX_position(xp_b), .playerO_position(op_b), .board(board_b),
    .who(who_b), .winner_play(wp_b), .turn(turn_b), .illegal(ill_b),
    .timeout_evt(to_b), .done(done_b), .dbg_state(st_b)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model of game A ----------------
  int         m_cell[NA*NA];
  int         m_turn, m_who, m_idle;
  bit         m_chk, m_ill, m_to;
  logic [8:0] m_wp;

  function automatic int line_cell(input int l, input int k);
    if (l < NA)          return l*NA + k;
    else if (l < 2*NA)   return k*NA + (l - NA);
    else if (l == 2*NA)  return k*NA + k;
    else                 return k*NA + (NA-1-k);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NA*NA; i++) m_cell[i] = 0;
    m_turn = 0; m_who = 0; m_idle = 0; m_chk = 0; m_wp = '0;
    m_ill = 0; m_to = 0;
  endtask

  task automatic m_judge();
    int  mark;
    bit  any, all, full;
    mark = m_turn + 1;
    any  = 0;
    m_wp = '0;
    for (int l = 0; l < 2*NA+2; l++) begin
      all = 1;
      for (int k = 0; k < NA; k++) if (m_cell[line_cell(l, k)] != mark) all = 0;
      if (all) begin
        any = 1;
        for (int k = 0; k < NA; k++) m_wp[line_cell(l, k)] = 1'b1;
      end
    end
    full = 1;
    for (int i = 0; i < NA*NA; i++) if (m_cell[i] == 0) full = 0;
    if (any)       m_who = mark;
    else if (full) m_who = 3;
    else           m_turn = 1 - m_turn;
  endtask

  // Advance the model by one clock edge using the inputs now applied to A.
  task automatic m_step();
    int req, pos;
    m_ill = 0;
    m_to  = 0;
    if (!rst || ng_a) begin
      m_clear();
    end else if (m_who != 0) begin
      m_who = m_who;
    end else if (m_chk) begin
      m_chk = 0;
      m_judge();
    end else begin
      req = (m_turn == 1) ? int'(po_a) : int'(px_a);
      pos = (m_turn == 1) ? int'(op_a) : int'(xp_a);
      if (req == 1 && pos < NA*NA && m_cell[pos % (NA*NA)] == 0) begin
        m_cell[pos] = m_turn + 1;
        m_chk  = 1;
        m_idle = 0;
      end else begin
        if (req == 1) m_ill = 1;
        if (m_idle == TO_A-1) begin
          m_to   = 1;
          m_turn = 1 - m_turn;
          m_idle = 0;
        end else begin
          m_idle++;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_a(input string ph);
    logic [17:0] eb;
    for (int i = 0; i < NA*NA; i++) eb[2*i +: 2] = 2'(m_cell[i]);
    chk({ph, ".board"},  64'(board_a), 64'(eb));
    chk({ph, ".who"},    64'(who_a),   64'(m_who));
    chk({ph, ".wp"},     64'(wp_a),    64'(m_wp));
    chk({ph, ".turn"},   64'(turn_a),  64'(m_turn));
    chk({ph, ".ill"},    64'(ill_a),   64'(m_ill));
    chk({ph, ".tout"},   64'(to_a),    64'(m_to));
    chk({ph, ".done"},   64'(done_a),  64'(m_who != 0));
  endtask

  string phase = "init";

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
    chk_a(phase);
  endtask

  // ---------------- drivers ----------------
  task automatic move_a(input int pl, input int pos);
    if (pl == 0) begin px_a = 1'b1; xp_a = 4'(pos); end
    else         begin po_a = 1'b1; op_a = 4'(pos); end
    tick();
    px_a = 1'b0; po_a = 1'b0;
    tick();
  endtask

  task automatic move_b(input int pl, input int pos);
    if (pl == 0) begin px_b = 1'b1; xp_b = 4'(pos); end
    else         begin po_b = 1'b1; op_b = 4'(pos); end
    tick();
    px_b = 1'b0; po_b = 1'b0;
    tick();
  endtask

  task automatic new_game_a();
    ng_a = 1'b1;
    tick();
    ng_a = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    ng_a = 0; px_a = 0; po_a = 0; xp_a = '0; op_a = '0;
    ng_b = 0; px_b = 0; po_b = 0; xp_b = '0; op_b = '0;
    m_clear();
    #1 rst = 1'b0;
    #2;
    phase = "reset";
    chk_a(phase);
    chk("B.rst.board", 64'(board_b), 64'h0);
    chk("B.rst.turn",  64'(turn_b),  64'h0);
    chk("B.rst.done",  64'(done_b),  64'h0);
    tick();
    tick();
    rst = 1'b1;

    // X wins on the top row
    phase = "xrow";
    move_a(0, 0); move_a(1, 3); move_a(0, 1); move_a(1, 4); move_a(0, 2);
    chk("xrow.who",   64'(who_a),        64'h1);
    chk("xrow.wp",    64'(wp_a),         64'h7);
    chk("xrow.done",  64'(done_a),       64'h1);
    chk("xrow.cells", 64'(board_a[5:0]), 64'h15);
    px_a = 1'b1; xp_a = 4'd8;
    tick();
    px_a = 1'b0;
    chk("xrow.hold",  64'(board_a[17:16]), 64'h0);
    new_game_a();
    chk("ng.board", 64'(board_a), 64'h0);
    chk("ng.who",   64'(who_a),   64'h0);
    chk("ng.turn",  64'(turn_a),  64'h0);

    // wrong player ignored, occupied cell rejected
    phase = "illegal";
    move_a(0, 4);
    px_a = 1'b1; xp_a = 4'd5;
    tick();
    px_a = 1'b0;
    chk("ign.ill",   64'(ill_a),            64'h0);
    chk("ign.cell5", 64'(board_a[11:10]),   64'h0);
    po_a = 1'b1; op_a = 4'd4;
    tick();
    po_a = 1'b0;
    chk("occ.ill",   64'(ill_a),          64'h1);
    chk("occ.cell4", 64'(board_a[9:8]),   64'h1);
    tick();
    chk("occ.pulse", 64'(ill_a),          64'h0);
    new_game_a();

    // draw
    phase = "draw";
    move_a(0, 0); move_a(1, 1); move_a(0, 2); move_a(1, 4); move_a(0, 3);
    move_a(1, 5); move_a(0, 7); move_a(1, 6); move_a(0, 8);
    chk("draw.who",  64'(who_a),  64'h3);
    chk("draw.wp",   64'(wp_a),   64'h0);
    chk("draw.done", 64'(done_a), 64'h1);
    new_game_a();

    // timeout forfeit, out-of-range move, accept on expiry edge
    phase = "tout";
    for (int i = 0; i < TO_A-1; i++) tick();
    chk("tout.early", 64'(to_a), 64'h0);
    tick();
    chk("tout.evt",  64'(to_a),   64'h1);
    chk("tout.turn", 64'(turn_a), 64'h1);
    po_a = 1'b1; op_a = 4'd9;
    tick();
    po_a = 1'b0;
    chk("oor.ill", 64'(ill_a), 64'h1);
    for (int i = 0; i < TO_A-2; i++) tick();
    po_a = 1'b1; op_a = 4'd0;
    tick();
    po_a = 1'b0;
    chk("edge.tout", 64'(to_a),         64'h0);
    chk("edge.cell", 64'(board_a[1:0]), 64'h2);
    tick();
    chk("edge.turn", 64'(turn_a), 64'h0);
    new_game_a();

    // asynchronous reset while in CHECK
    phase = "arst";
    px_a = 1'b1; xp_a = 4'd4;
    tick();
    px_a = 1'b0;
    #2 rst = 1'b0;
    #1;
    m_clear();
    chk_a(phase);
    chk("arst.board", 64'(board_a), 64'h0);
    chk("arst.state", 64'(st_a),    64'h0);
    tick();
    rst = 1'b1;

    // 4x4 main-diagonal win on instance B
    phase = "b4";
    move_b(0, 0);
    chk("b4.turn", 64'(turn_b), 64'h1);
    move_b(1, 1); move_b(0, 5); move_b(1, 2); move_b(0, 10); move_b(1, 3);
    move_b(0, 15);
    chk("b4.who",  64'(who_b),  64'h1);
    chk("b4.wp",   64'(wp_b),   64'h8421);
    chk("b4.done", 64'(done_b), 64'h1);
    chk("b4.tout", 64'(to_b),   64'h0);

    // randomized play on instance A
    phase = "rand";
    new_game_a();
    for (int k = 0; k < 1500; k++) begin
      ng_a = ($urandom_range(0, 59) == 0);
      px_a = ($urandom_range(0, 3) == 0);
      po_a = ($urandom_range(0, 3) == 0);
      xp_a = 4'($urandom_range(0, 10));
      op_a = 4'($urandom_range(0, 10));
      tick();
    end
    ng_a = 0; px_a = 0; po_a = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
